// File: rtl/cpu_pkg.sv
// Shared constants and handshake encoding for the CPU input capture path.
package cpu_pkg;

   localparam int CPU_DATA_W          = 4;
   localparam int CPU_SYNC_STAGES     = 2;
   localparam int CPU_DEBOUNCE_CYCLES = 500000;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } hs_state_e;

endpackage

// File: rtl/cpu_debounce.sv
// Active-low button synchronizer and debouncer.
// Produces the debounced level and a one-cycle press strobe.
module cpu_debounce
   import cpu_pkg::*;
#(
   parameter int SYNC_STAGES     = CPU_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = CPU_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic key_level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   mismatch;
   logic                   expire;

   // Synced key is active-low; level is active-high.
   assign mismatch = (~sync_q[SYNC_STAGES-1]) != level_q;
   assign expire   = mismatch && (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (expire) begin
         level_d = ~level_q;
      end else if (mismatch) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '1;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign key_level = level_q;
   assign press     = expire && !level_q;

endmodule

// File: rtl/cpu_input_capture.sv
// Switch/button operand capture with valid/ack handshake to the CPU FSM.
// Optional: CPU_INPUT_OVERWRITE_EN makes a press while VALID replace the operand.
module cpu_input_capture
   import cpu_pkg::*;
#(
   parameter int DATA_W          = CPU_DATA_W,
   parameter int SYNC_STAGES     = CPU_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = CPU_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sw_in,
   input  logic              key_n,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ack,
   output logic              key_level,
   output logic              overrun
);

   logic [DATA_W-1:0] sw_sync_q [SYNC_STAGES];
   logic [DATA_W-1:0] sw_s;
   logic              press;
   hs_state_e         state_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              overrun_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      end else begin
         sw_sync_q[0] <= sw_in;
         for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
      end
   end

   assign sw_s = sw_sync_q[SYNC_STAGES-1];

   cpu_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clk      (clk),
      .reset    (reset),
      .key_n    (key_n),
      .key_level(key_level),
      .press    (press)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (press) begin
                  data_q  <= sw_s;
                  valid_q <= 1'b1;
                  state_q <= ST_VALID;
               end
            end
            ST_VALID: begin
               // An ack always retires the current operand, even with a press.
               if (press) begin
                  overrun_q <= 1'b1;
`ifdef CPU_INPUT_OVERWRITE_EN
                  data_q <= sw_s;
`endif
               end
               if (data_ack) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_cpu_input_capture.sv
// Directed self-checking bench for cpu_input_capture.
module tb_cpu_input_capture;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sw_in;
   logic       key_n;
   logic [3:0] data_out;
   logic       data_valid;
   logic       data_ack;
   logic       key_level;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_input_capture #(
      .DATA_W         (4),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_in     (sw_in),
      .key_n     (key_n),
      .data_out  (data_out),
      .data_valid(data_valid),
      .data_ack  (data_ack),
      .key_level (key_level),
      .overrun   (overrun)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dout"}, 32'(data_out), 32'h0);
      check({tag, "_valid"}, 32'(data_valid), 32'h0);
      check({tag, "_klvl"}, 32'(key_level), 32'h0);
      check({tag, "_ovr"}, 32'(overrun), 32'h0);
   endtask

   logic [3:0] exp_ovr_data;

   initial begin
`ifdef CPU_INPUT_OVERWRITE_EN
      exp_ovr_data = 4'h5;
`else
      exp_ovr_data = 4'h3;
`endif
      reset    = 1'b1;
      sw_in    = 4'hF;
      key_n    = 1'b0;
      data_ack = 1'b0;

      step(1);
      check_reset_vals("rst_c1");
      step(2);
      check_reset_vals("rst_c3");
      reset = 1'b0;
      step(1);
      check_reset_vals("rst_after");
      key_n = 1'b1;
      step(10);
      check("idle_valid", 32'(data_valid), 32'h0);

      // Clean press from edge t
      sw_in = 4'hA;
      key_n = 1'b0;
      step(5);
      check("clean_t5_klvl", 32'(key_level), 32'h0);
      check("clean_t5_valid", 32'(data_valid), 32'h0);
      step(1);
      check("clean_t6_klvl", 32'(key_level), 32'h1);
      check("clean_t6_valid", 32'(data_valid), 32'h1);
      check("clean_t6_dout", 32'(data_out), 32'hA);
      data_ack = 1'b1;
      step(1);
      data_ack = 1'b0;
      check("ack_valid", 32'(data_valid), 32'h0);
      check("ack_dout", 32'(data_out), 32'hA);

      // Stray ack while idle
      data_ack = 1'b1;
      step(1);
      data_ack = 1'b0;
      check("stray_valid", 32'(data_valid), 32'h0);
      check("stray_dout", 32'(data_out), 32'hA);
      key_n = 1'b1;
      step(8);
      check("release_klvl", 32'(key_level), 32'h0);
      check("release_valid", 32'(data_valid), 32'h0);

      // Bounce rejection
      for (int i = 0; i < 5; i++) begin
         key_n = 1'b0;
         step(2);
         check("bounce_klvl", 32'(key_level), 32'h0);
         key_n = 1'b1;
         step(2);
         check("bounce_valid", 32'(data_valid), 32'h0);
      end
      sw_in = 4'hC;
      key_n = 1'b0;
      step(5);
      check("bhold_t5_valid", 32'(data_valid), 32'h0);
      step(1);
      check("bhold_t6_valid", 32'(data_valid), 32'h1);
      check("bhold_t6_dout", 32'(data_out), 32'hC);
      data_ack = 1'b1;
      step(1);
      data_ack = 1'b0;
      key_n = 1'b1;
      step(8);

      // Overrun
      sw_in = 4'h3;
      key_n = 1'b0;
      step(6);
      check("ovr1_valid", 32'(data_valid), 32'h1);
      check("ovr1_dout", 32'(data_out), 32'h3);
      key_n = 1'b1;
      step(8);
      check("ovr1_rel_klvl", 32'(key_level), 32'h0);
      check("ovr1_rel_valid", 32'(data_valid), 32'h1);
      check("ovr1_rel_ovr", 32'(overrun), 32'h0);
      sw_in = 4'h9;
      step(3);
      check("swtrack_dout", 32'(data_out), 32'h3);
      sw_in = 4'h5;
      key_n = 1'b0;
      step(6);
      check("ovr2_ovr", 32'(overrun), 32'h1);
      check("ovr2_valid", 32'(data_valid), 32'h1);
      check("ovr2_dout", 32'(data_out), 32'(exp_ovr_data));

      // Reset while VALID with release debounce partly counted
      key_n = 1'b1;
      step(3);
      check("mid_klvl", 32'(key_level), 32'h1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_reset_vals("midrst");
      step(4);
      sw_in = 4'h6;
      key_n = 1'b0;
      step(6);
      check("post_valid", 32'(data_valid), 32'h1);
      check("post_dout", 32'(data_out), 32'h6);
      check("post_klvl", 32'(key_level), 32'h1);
      check("post_ovr", 32'(overrun), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
